sb_line_follow_ctrl: RTL and testbench

Upstream decision stage for the bot turn controller: converts three line-sensor ADC readings into the 3-bit turn command (stop/forward/left/right/extreme) consumed by the motor PWM stage. It thresholds and debounces the sensor pattern, detects and counts nodes (all sensors on line), and recovers from line loss. It sits between the ADC sampler and the turn-control/PWM block, and runs on clk_50.

---
 rtl/sb_bot_pkg.sv | 47 ++++
 rtl/sb_line_follow_ctrl_if.sv | 30 +++
 rtl/sb_sensor_debounce.sv | 59 +++++
 rtl/sb_line_follow_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sb_line_follow_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sb_bot_pkg.sv
// Shared definitions for the bot line-follow / turn-control path.
// Contents: turn command codes (also used by the turn-control/PWM block),
// the debounced sensor class enum, the line-follow FSM state enum, and the
// raw {L,C,R} pattern classifier.
// Build option: SB_LOST_SEARCH_EN adds the SEARCH state.
package sb_bot_pkg;

    localparam logic [2:0] TURN_STOP    = 3'b000;
    localparam logic [2:0] TURN_FWD     = 3'b001;
    localparam logic [2:0] TURN_LEFT    = 3'b010;
    localparam logic [2:0] TURN_RIGHT   = 3'b011;
    localparam logic [2:0] TURN_EXTREME = 3'b100;

    typedef enum logic [2:0] {
        CLS_LOST,
        CLS_FWD,
        CLS_LEFT,
        CLS_RIGHT,
        CLS_NODE,
        CLS_HOLD
    } sensor_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FOLLOW,
        ST_NODE,
`ifdef SB_LOST_SEARCH_EN
        ST_SEARCH,
`endif
        ST_DONE
    } state_e;

    // lcr = {left, centre, right} on-line flags
    function automatic sensor_class_e classify(input logic [2:0] lcr);
        sensor_class_e c;
        case (lcr)
            3'b010:         c = CLS_FWD;
            3'b110, 3'b100: c = CLS_LEFT;
            3'b011, 3'b001: c = CLS_RIGHT;
            3'b111:         c = CLS_NODE;
            3'b000:         c = CLS_LOST;
            default:        c = CLS_HOLD;  // 101: outer sensors only, ambiguous
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sb_line_follow_ctrl_if.sv
// Control/sensor bundle between the ADC sampler, the run controller and
// sb_line_follow_ctrl.
// master: drives start, target_nodes, sample_valid, adc_*; observes results.
// slave : sb_line_follow_ctrl side; drives turn, node_pulse, node_count,
//         busy, done.
interface sb_line_follow_ctrl_if #(
    parameter int ADC_W = 12
);
    logic             start;
    logic [3:0]       target_nodes;
    logic             sample_valid;
    logic [ADC_W-1:0] adc_left;
    logic [ADC_W-1:0] adc_center;
    logic [ADC_W-1:0] adc_right;
    logic [2:0]       turn;
    logic             node_pulse;
    logic [3:0]       node_count;
    logic             busy;
    logic             done;

    modport master (
        output start, target_nodes, sample_valid, adc_left, adc_center, adc_right,
        input  turn, node_pulse, node_count, busy, done
    );

    modport slave (
        input  start, target_nodes, sample_valid, adc_left, adc_center, adc_right,
        output turn, node_pulse, node_count, busy, done
    );
endinterface

// File: rtl/sb_sensor_debounce.sv
// Thresholds the three ADC readings, encodes the sensor class and debounces
// it with a saturating run counter.
// Ports: clk_50, rst_n (sync, active-low), clear (drops history; a sample
// in the same cycle is discarded), sample_valid, adc_left/center/right in;
// acc_valid (combinational strobe, same cycle as the accepting sample) and
// acc_class out.
// Once a run reaches DEBOUNCE every further identical sample is accepted
// again, so a steady pattern yields one acceptance per strobe.
module sb_sensor_debounce
    import sb_bot_pkg::*;
#(
    parameter int ADC_W    = 12,
    parameter int THRESH   = 1500,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] adc_left,
    input  logic [ADC_W-1:0] adc_center,
    input  logic [ADC_W-1:0] adc_right,
    output logic             acc_valid,
    output sensor_class_e    acc_class
);
    sensor_class_e cls;
    sensor_class_e prev_q, prev_d;
    logic [3:0]    run_q, run_d;  // 0 = no previous sample

    always_comb begin
        cls = classify({adc_left   > ADC_W'(THRESH),
                        adc_center > ADC_W'(THRESH),
                        adc_right  > ADC_W'(THRESH)});
        prev_d    = prev_q;
        run_d     = run_q;
        acc_valid = 1'b0;
        acc_class = cls;
        if (clear) begin
            run_d = '0;
        end else if (sample_valid) begin
            prev_d = cls;
            if (run_q != '0 && cls == prev_q)
                run_d = (run_q >= 4'(DEBOUNCE)) ? 4'(DEBOUNCE) : run_q + 4'd1;
            else
                run_d = 4'd1;
            acc_valid = (run_d == 4'(DEBOUNCE));
        end
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            prev_q <= CLS_LOST;
            run_q  <= '0;
        end else begin
            prev_q <= prev_d;
            run_q  <= run_d;
        end
    end
endmodule

// File: rtl/sb_line_follow_ctrl.sv
// Line-follow decision stage: debounced sensor classes -> 3-bit turn command,
// node detection/counting and line-loss handling.
// Ports: clk_50, rst_n (sync, active-low), bus (sb_line_follow_ctrl_if.slave:
// start, target_nodes, sample_valid, adc_* in; turn, node_pulse, node_count,
// busy, done out, all registered). Interface ADC_W must equal ADC_W here.
// Build option: define SB_LOST_SEARCH_EN for SEARCH spin recovery after line
// loss; otherwise LOST_SAMPLES consecutive lost acceptances end the run.
module sb_line_follow_ctrl
    import sb_bot_pkg::*;
#(
    parameter int ADC_W         = 12,
    parameter int THRESH        = 1500,
    parameter int DEBOUNCE      = 3,
    parameter int NODE_HOLD_CYC = 25000000,
    parameter int LOST_SAMPLES  = 8,
    parameter int SEARCH_CYC    = 100000000
) (
    input logic                   clk_50,
    input logic                   rst_n,
    sb_line_follow_ctrl_if.slave  bus
);
    localparam int LOST_W = $clog2(LOST_SAMPLES + 1);

    state_e            state_q, state_d;
    logic [2:0]        turn_q, turn_d;
    logic              node_pulse_q, node_pulse_d;
    logic [3:0]        node_count_q, node_count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LOST_W-1:0] lost_q, lost_d;
    logic [31:0]       hold_q, hold_d;
`ifdef SB_LOST_SEARCH_EN
    logic [31:0]       search_q, search_d;
`endif
    logic              db_clear;
    logic              acc_valid;
    sensor_class_e     acc_class;
    logic              take_node;
    logic [3:0]        cnt_inc;

    sb_sensor_debounce #(
        .ADC_W    (ADC_W),
        .THRESH   (THRESH),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk_50       (clk_50),
        .rst_n        (rst_n),
        .clear        (db_clear),
        .sample_valid (bus.sample_valid),
        .adc_left     (bus.adc_left),
        .adc_center   (bus.adc_center),
        .adc_right    (bus.adc_right),
        .acc_valid    (acc_valid),
        .acc_class    (acc_class)
    );

    always_comb begin
        state_d      = state_q;
        turn_d       = turn_q;
        node_pulse_d = 1'b0;
        node_count_d = node_count_q;
        lost_d       = lost_q;
        hold_d       = hold_q;
        db_clear     = 1'b0;
        take_node    = 1'b0;
`ifdef SB_LOST_SEARCH_EN
        search_d     = search_q;
`endif
        cnt_inc = (node_count_q == 4'hF) ? 4'hF : node_count_q + 4'd1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d      = ST_FOLLOW;
                    turn_d       = TURN_STOP;
                    node_count_d = '0;
                    lost_d       = '0;
                    db_clear     = 1'b1;
                end
            end
            ST_FOLLOW: begin
                if (acc_valid) begin
                    case (acc_class)
                        CLS_FWD:   begin turn_d = TURN_FWD;   lost_d = '0; end
                        CLS_LEFT:  begin turn_d = TURN_LEFT;  lost_d = '0; end
                        CLS_RIGHT: begin turn_d = TURN_RIGHT; lost_d = '0; end
                        CLS_HOLD:  lost_d = '0;
                        CLS_NODE:  take_node = 1'b1;
                        CLS_LOST: begin
                            if (lost_q + LOST_W'(1) >= LOST_W'(LOST_SAMPLES)) begin
                                lost_d = '0;
`ifdef SB_LOST_SEARCH_EN
                                state_d  = ST_SEARCH;
                                turn_d   = TURN_EXTREME;
                                search_d = '0;
`else
                                state_d = ST_DONE;
                                turn_d  = TURN_STOP;
`endif
                            end else begin
                                lost_d = lost_q + LOST_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_NODE: begin
                // Sensors ignored; debounce history dropped on exit so the
                // node just left cannot be counted twice.
                if (hold_q + 32'd1 >= 32'(NODE_HOLD_CYC)) begin
                    state_d  = ST_FOLLOW;
                    hold_d   = '0;
                    lost_d   = '0;
                    db_clear = 1'b1;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
`ifdef SB_LOST_SEARCH_EN
            ST_SEARCH: begin
                if (acc_valid && (acc_class == CLS_FWD || acc_class == CLS_LEFT ||
                                  acc_class == CLS_RIGHT)) begin
                    state_d = ST_FOLLOW;
                    lost_d  = '0;
                    turn_d  = (acc_class == CLS_FWD)  ? TURN_FWD :
                              (acc_class == CLS_LEFT) ? TURN_LEFT : TURN_RIGHT;
                end else if (acc_valid && acc_class == CLS_NODE) begin
                    take_node = 1'b1;
                end else if (search_q + 32'd1 >= 32'(SEARCH_CYC)) begin
                    state_d = ST_DONE;
                    turn_d  = TURN_STOP;
                end else begin
                    search_d = search_q + 32'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                turn_d  = TURN_STOP;
            end
        endcase

        if (take_node) begin
            node_count_d = cnt_inc;
            node_pulse_d = 1'b1;
            lost_d       = '0;
            if (bus.target_nodes != 4'd0 && cnt_inc == bus.target_nodes) begin
                state_d = ST_DONE;
                turn_d  = TURN_STOP;
            end else begin
                state_d = ST_NODE;
                turn_d  = TURN_FWD;
                hold_d  = '0;
            end
        end

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            turn_q       <= TURN_STOP;
            node_pulse_q <= 1'b0;
            node_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            lost_q       <= '0;
            hold_q       <= '0;
`ifdef SB_LOST_SEARCH_EN
            search_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            turn_q       <= turn_d;
            node_pulse_q <= node_pulse_d;
            node_count_q <= node_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            lost_q       <= lost_d;
            hold_q       <= hold_d;
`ifdef SB_LOST_SEARCH_EN
            search_q     <= search_d;
`endif
        end
    end

    assign bus.turn       = turn_q;
    assign bus.node_pulse = node_pulse_q;
    assign bus.node_count = node_count_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_sb_line_follow_ctrl.sv
// Self-checking bench for sb_line_follow_ctrl: directed scenarios followed by
// randomized sensor segments, every cycle compared against a reference model.
module tb_sb_line_follow_ctrl;
    localparam int ADC_W      = 12;
    localparam int THRESH     = 1500;
    localparam int DEBOUNCE   = 3;
    localparam int NODE_HOLD  = 20;
    localparam int LOST       = 8;
    localparam int SEARCH_CYC = 300;

    // reference model modes
    localparam int M_IDLE = 0, M_FOLLOW = 1, M_NODE = 2, M_SEARCH = 3, M_DONE = 4;
    // reference classes: direction classes carry their turn code
    localparam int K_LOST = 0, K_FWD = 1, K_LEFT = 2, K_RIGHT = 3, K_HOLD = 5, K_NODE = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sb_line_follow_ctrl_if #(.ADC_W(ADC_W)) bus ();

    sb_line_follow_ctrl #(
        .ADC_W         (ADC_W),
        .THRESH        (THRESH),
        .DEBOUNCE      (DEBOUNCE),
        .NODE_HOLD_CYC (NODE_HOLD),
        .LOST_SAMPLES  (LOST),
        .SEARCH_CYC    (SEARCH_CYC)
    ) dut (
        .clk_50 (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pulses_seen = 0;

    int m_mode = M_IDLE;
    int m_turn = 0, m_pulse = 0, m_count = 0, m_lost = 0, m_hold = 0, m_search = 0;
    int hist[$];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify_ref(input bit l, input bit c, input bit r);
        int k;
        case ({l, c, r})
            3'b010:         k = K_FWD;
            3'b110, 3'b100: k = K_LEFT;
            3'b011, 3'b001: k = K_RIGHT;
            3'b111:         k = K_NODE;
            3'b000:         k = K_LOST;
            default:        k = K_HOLD;
        endcase
        return k;
    endfunction

    function automatic int adc_for(input bit on);
        int r;
        r = int'($urandom_range(0, 3));
        if (on) return (r == 0) ? THRESH + 1 : int'($urandom_range(THRESH + 1, 4095));
        else    return (r == 0) ? THRESH     : int'($urandom_range(0, THRESH));
    endfunction

    task automatic take_node(input int tgt);
        m_count = (m_count >= 15) ? 15 : m_count + 1;
        m_pulse = 1;
        m_lost  = 0;
        if (tgt != 0 && m_count == tgt) begin
            m_mode = M_DONE; m_turn = 0;
        end else begin
            m_mode = M_NODE; m_turn = 1; m_hold = 0;
        end
    endtask

    // Predicts the registered outputs after the coming clock edge.
    task automatic model_step(input bit rst, input bit st, input bit sv,
                              input int al, input int ac, input int ar, input int tgt);
        bit acc;
        int k;
        m_pulse = 0;
        acc = 0;
        k = -1;
        if (!rst) begin
            m_mode = M_IDLE; m_turn = 0; m_count = 0; m_lost = 0;
            hist.delete();
            return;
        end
        case (m_mode)
            M_IDLE, M_DONE: begin
                if (st) begin
                    m_mode = M_FOLLOW; m_turn = 0; m_count = 0; m_lost = 0;
                    hist.delete();
                end
            end
            M_NODE: begin
                m_hold++;
                if (m_hold >= NODE_HOLD) begin
                    m_mode = M_FOLLOW; m_lost = 0;
                    hist.delete();
                end
            end
            default: begin
                if (sv) begin
                    k = classify_ref(al > THRESH, ac > THRESH, ar > THRESH);
                    hist.push_back(k);
                    if (hist.size() > DEBOUNCE) void'(hist.pop_front());
                    acc = (hist.size() == DEBOUNCE);
                    foreach (hist[j]) if (hist[j] != k) acc = 0;
                end
                if (m_mode == M_FOLLOW) begin
                    if (acc) begin
                        if (k == K_FWD || k == K_LEFT || k == K_RIGHT) begin
                            m_turn = k; m_lost = 0;
                        end else if (k == K_HOLD) begin
                            m_lost = 0;
                        end else if (k == K_NODE) begin
                            take_node(tgt);
                        end else begin
                            m_lost++;
                            if (m_lost >= LOST) begin
                                m_lost = 0;
`ifdef SB_LOST_SEARCH_EN
                                m_mode = M_SEARCH; m_turn = 4; m_search = 0;
`else
                                m_mode = M_DONE; m_turn = 0;
`endif
                            end
                        end
                    end
                end else begin
                    if (acc && (k == K_FWD || k == K_LEFT || k == K_RIGHT)) begin
                        m_mode = M_FOLLOW; m_turn = k; m_lost = 0;
                    end else if (acc && k == K_NODE) begin
                        take_node(tgt);
                    end else begin
                        m_search++;
                        if (m_search >= SEARCH_CYC) begin
                            m_mode = M_DONE; m_turn = 0;
                        end
                    end
                end
            end
        endcase
    endtask

    // Drive one clock of stimulus (called at negedge), then compare at the
    // following negedge.
    task automatic cycle(input bit rst, input bit st, input bit sv, input bit [2:0] pat);
        int al, ac, ar;
        al = adc_for(pat[2]);
        ac = adc_for(pat[1]);
        ar = adc_for(pat[0]);
        rst_n            = rst;
        bus.start        = st;
        bus.sample_valid = sv;
        bus.adc_left     = ADC_W'(al);
        bus.adc_center   = ADC_W'(ac);
        bus.adc_right    = ADC_W'(ar);
        model_step(rst, st, sv, al, ac, ar, int'(bus.target_nodes));
        @(posedge clk);
        @(negedge clk);
        check("turn",       int'(bus.turn),       m_turn);
        check("node_pulse", int'(bus.node_pulse), m_pulse);
        check("node_count", int'(bus.node_count), m_count);
        check("busy",       int'(bus.busy),       int'(m_mode == M_FOLLOW || m_mode == M_NODE || m_mode == M_SEARCH));
        check("done",       int'(bus.done),       int'(m_mode == M_DONE));
        if (bus.node_pulse) pulses_seen++;
    endtask

    task automatic strobes(input bit [2:0] pat, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b1, pat);
    endtask

    int saved_count;
    int seg_left;
    int pick;
    bit [2:0] seg_pat;
    bit r_b, s_b, v_b;

    initial begin
        bus.start = 1'b0;
        bus.target_nodes = 4'd0;
        bus.sample_valid = 1'b0;
        bus.adc_left = '0;
        bus.adc_center = '0;
        bus.adc_right = '0;
        @(negedge clk);

        // reset state
        cycle(1'b0, 1'b0, 1'b0, 3'b000);
        cycle(1'b0, 1'b1, 1'b1, 3'b010);
        check("rst_turn", int'(bus.turn), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);

        // debounce: 010 x2 then 110 x3
        cycle(1'b1, 1'b1, 1'b0, 3'b000);
        strobes(3'b010, 2);
        check("db_010x2", int'(bus.turn), 0);
        strobes(3'b110, 2);
        check("db_110x2", int'(bus.turn), 0);
        strobes(3'b110, 1);
        check("db_left", int'(bus.turn), 2);

        // reset mid-run with turn=010
        cycle(1'b0, 1'b0, 1'b1, 3'b010);
        check("midrst_turn", int'(bus.turn), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_cnt", int'(bus.node_count), 0);

        // two nodes, target 2
        bus.target_nodes = 4'd2;
        cycle(1'b1, 1'b1, 1'b0, 3'b000);
        strobes(3'b010, 3);
        pulses_seen = 0;
        strobes(3'b111, 3);
        check("node1_cnt", int'(bus.node_count), 1);
        check("node1_turn", int'(bus.turn), 1);
        strobes(3'b111, NODE_HOLD);
        check("hold_pulses", pulses_seen, 1);
        strobes(3'b010, 3);
        strobes(3'b111, 3);
        check("node2_pulses", pulses_seen, 2);
        check("node2_cnt", int'(bus.node_count), 2);
        check("node2_done", int'(bus.done), 1);
        check("node2_turn", int'(bus.turn), 0);

        // line loss
        bus.target_nodes = 4'd0;
        cycle(1'b1, 1'b1, 1'b0, 3'b000);
        strobes(3'b010, 3);
        strobes(3'b000, 9);
        check("lost7_keep", int'(bus.turn), 1);
        strobes(3'b000, 1);
`ifdef SB_LOST_SEARCH_EN
        check("lost_spin", int'(bus.turn), 4);
        check("lost_busy", int'(bus.busy), 1);
        strobes(3'b011, 3);
        check("search_right", int'(bus.turn), 3);
        check("search_busy", int'(bus.busy), 1);
`else
        check("lost_done", int'(bus.done), 1);
        check("lost_stop", int'(bus.turn), 0);
`endif

        // 101 hold and start while busy
        cycle(1'b0, 1'b0, 1'b0, 3'b000);
        cycle(1'b1, 1'b1, 1'b0, 3'b000);
        strobes(3'b111, 3);
        for (int i = 0; i < NODE_HOLD; i++) cycle(1'b1, 1'b0, 1'b0, 3'b000);
        strobes(3'b010, 3);
        check("pre101_turn", int'(bus.turn), 1);
        strobes(3'b101, 3);
        check("hold101_turn", int'(bus.turn), 1);
        saved_count = int'(bus.node_count);
        cycle(1'b1, 1'b1, 1'b0, 3'b000);
        check("busy_start_cnt", int'(bus.node_count), saved_count);
        check("busy_start_busy", int'(bus.busy), 1);

        // randomized segments
        seg_left = 0;
        seg_pat = 3'b010;
        for (int i = 0; i < 3000; i++) begin
            if (seg_left == 0) begin
                pick = int'($urandom_range(0, 9));
                case (pick)
                    0, 1, 2, 3: seg_pat = 3'b010;
                    4:          seg_pat = $urandom_range(0, 1) ? 3'b110 : 3'b100;
                    5:          seg_pat = $urandom_range(0, 1) ? 3'b011 : 3'b001;
                    6:          seg_pat = 3'b111;
                    7, 8:       seg_pat = 3'b000;
                    default:    seg_pat = 3'b101;
                endcase
                seg_left = int'($urandom_range(1, 12));
            end
            v_b = ($urandom_range(0, 3) != 0);
            if (v_b) seg_left--;
            r_b = ($urandom_range(0, 799) != 0);
            s_b = ($urandom_range(0, 39) == 0);
            if (s_b) bus.target_nodes = 4'($urandom_range(0, 3));
            cycle(r_b, s_b, v_b, seg_pat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
